mlp_engine: RTL

// - Parametrised 1-hidden-layer MLP core (NH ReLU hidden units, 1 sigmoid output unit). Successor to the fixed 30-unit block.
// - Adds: integrated sequencing FSM, synchronous reset, runtime weight load/readback port, valid/ready pattern handshake.
// - Adds: per-pattern train/validate mode, freeze-update mode, and saturating error/pattern statistics.
// - Sits between the pattern source and the top-level controller; one pattern in flight at a time.

---
 rtl/mlp_pkg.sv | 19 +
 rtl/mlp_neuron.sv | 101 ++++++++++
 rtl/mlp_seq.sv | 67 ++++++
 rtl/mlp_engine.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared types and encodings for the MLP engine: sequencer states, pattern modes, default sizes.
package mlp_pkg;
  typedef enum logic [2:0] {IDLE, FPH, FPO, BPO, BPH, UPD, DONE} state_e;

  localparam logic [1:0] MODE_VAL = 2'd0;
  localparam logic [1:0] MODE_TRN = 2'd1;
  localparam logic [1:0] MODE_DRY = 2'd2;

  localparam int NX_DEF   = 6;
  localparam int NH_DEF   = 30;
  localparam int BITS_DEF = 16;
  localparam int PHC_DEF  = 1;
  localparam int CW_DEF   = 16;

  // The reserved encoding behaves exactly like validate.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_VAL : m;
  endfunction
endpackage

// File: rtl/mlp_neuron.sv
// Q8.8 fixed-point neurons: ReLU hidden unit and hard-sigmoid output unit, each with local backprop.
module Neuron_ReLU #(
  parameter int NX   = 6,
  parameter int BITS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fp,
  input  logic                     bp,
  input  logic [NX:0][BITS-1:0]    w,
  input  logic [NX-1:0][BITS-1:0]  x,
  input  logic [BITS-1:0]          lr,
  input  logic [BITS-1:0]          delta,
  input  logic [BITS-1:0]          w_out,
  output logic [BITS-1:0]          h,
  output logic [NX:0][BITS-1:0]    w_new
);
  localparam int AW = 4 * BITS;

  logic signed [AW-1:0]   acc, dhw, g;
  logic signed [BITS-1:0] pre, dh;
  logic [NX:0][BITS-1:0]  w_new_n;

  always_comb begin
    acc = '0;
    for (int k = 0; k < NX; k++) acc = acc + AW'($signed(w[k+1])) * AW'($signed(x[k]));
    pre = BITS'(AW'($signed(w[0])) + (acc >>> 8));
    // Gradient only flows through units that were active in the forward pass.
    dhw = AW'($signed(w_out)) * AW'($signed(delta));
    dh  = (h != '0) ? BITS'(dhw >>> 8) : '0;
    g   = AW'($signed(lr)) * AW'(dh);
    w_new_n[0] = BITS'(AW'($signed(w[0])) + (g >>> 8));
    for (int k = 0; k < NX; k++)
      w_new_n[k+1] = BITS'(AW'($signed(w[k+1])) + ((g * AW'($signed(x[k]))) >>> 16));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h     <= '0;
      w_new <= '0;
    end else begin
      if (fp) h <= pre[BITS-1] ? '0 : pre;
      if (bp) w_new <= w_new_n;
    end
  end
endmodule

module Neuron_Sigmoid #(
  parameter int NH   = 30,
  parameter int BITS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fp,
  input  logic                     bp,
  input  logic [NH:0][BITS-1:0]    w,
  input  logic [NH-1:0][BITS-1:0]  h,
  input  logic [BITS-1:0]          y,
  input  logic [BITS-1:0]          lr,
  output logic [BITS-1:0]          yhat,
  output logic [BITS-1:0]          delta,
  output logic [NH:0][BITS-1:0]    w_new
);
  localparam int AW = 4 * BITS;

  logic signed [AW-1:0]   acc, s, tgt, dl, g;
  logic signed [BITS-1:0] z_n, z_q;
  logic [NH:0][BITS-1:0]  w_new_n;

  // Hard sigmoid clamp(0.5 + z/4, 0, 1); the 0.5 threshold reduces to z > 0.
  always_comb begin
    acc = '0;
    for (int j = 0; j < NH; j++) acc = acc + AW'($signed(w[j+1])) * AW'($signed(h[j]));
    z_n = BITS'(AW'($signed(w[0])) + (acc >>> 8));
    s   = (AW'(z_q) >>> 2) + AW'(128);
    if (s < 0) s = '0;
    else if (s > 256) s = AW'(256);
    tgt = (y != '0) ? AW'(256) : AW'(0);
    dl  = tgt - s;
    g   = AW'($signed(lr)) * dl;
    w_new_n[0] = BITS'(AW'($signed(w[0])) + (g >>> 8));
    for (int j = 0; j < NH; j++)
      w_new_n[j+1] = BITS'(AW'($signed(w[j+1])) + ((g * AW'($signed(h[j]))) >>> 16));
  end

  assign yhat = BITS'(z_q > 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q   <= '0;
      delta <= '0;
      w_new <= '0;
    end else begin
      if (fp) z_q <= z_n;
      if (bp) begin
        delta <= BITS'(dl);
        w_new <= w_new_n;
      end
    end
  end
endmodule

// File: rtl/mlp_seq.sv
// Pattern sequencer: walks IDLE -> FP -> (BP -> UPD) -> DONE and emits first-cycle phase strobes.
module mlp_seq
  import mlp_pkg::*;
#(
  parameter int PHC = PHC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic wl_en,
  input  logic train,
  output logic in_ready,
  output logic accept,
  output logic busy,
  output logic fph_stb,
  output logic fpo_stb,
  output logic bpo_stb,
  output logic bph_stb,
  output logic upd,
  output logic done
);
  localparam int PW = (PHC > 1) ? $clog2(PHC) : 1;

  state_e state, state_n;
  logic [PW-1:0] pcnt;
  logic ph_last, first;

  assign ph_last = (pcnt == PW'(PHC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pcnt  <= '0;
    end else begin
      state <= state_n;
      pcnt  <= (state_n != state || state == IDLE) ? '0 : pcnt + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept)  state_n = FPH;
      FPH:     if (ph_last) state_n = FPO;
      FPO:     if (ph_last) state_n = train ? BPO : DONE;
      BPO:     if (ph_last) state_n = BPH;
      BPH:     if (ph_last) state_n = UPD;
      UPD:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A weight write owns the idle cycle; the pattern waits.
  always_comb begin
    first    = (pcnt == '0);
    in_ready = (state == IDLE) && !wl_en;
    accept   = in_valid && in_ready;
    busy     = (state != IDLE);
    fph_stb  = (state == FPH) && first;
    fpo_stb  = (state == FPO) && first;
    bpo_stb  = (state == BPO) && first;
    bph_stb  = (state == BPH) && first;
    upd      = (state == UPD);
    done     = (state == DONE);
  end
endmodule

// File: rtl/mlp_engine.sv
// One-hidden-layer MLP core: weight storage, load/readback port, neuron array, commit and statistics.
module mlp_engine
  import mlp_pkg::*;
#(
  parameter int NX   = NX_DEF,
  parameter int NH   = NH_DEF,
  parameter int BITS = BITS_DEF,
  parameter int PHC  = PHC_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NX*BITS-1:0]              x,
  input  logic [BITS-1:0]                 y,
  input  logic [BITS-1:0]                 lr,
  input  logic [1:0]                      mode,
  output logic                            out_valid,
  output logic [BITS-1:0]                 yhat,
  output logic                            err,
  input  logic                            wl_en,
  input  logic                            wl_layer,
  input  logic [$clog2(NH*(NX+1))-1:0]    wl_addr,
  input  logic [BITS-1:0]                 wl_data,
  output logic [BITS-1:0]                 wr_data,
  input  logic                            clr_stats,
  output logic [CW-1:0]                   err_cnt,
  output logic [CW-1:0]                   pat_cnt,
  output logic                            busy
);
  localparam int AW = $clog2(NH*(NX+1));

  typedef logic [NX:0][BITS-1:0] w1_row_t;
  typedef logic [NH:0][BITS-1:0] w2_vec_t;

  w1_row_t [NH-1:0]         w1, w1_new;
  w2_vec_t                  w2, w2_new;
  logic [NX-1:0][BITS-1:0]  x_q;
  logic [NH-1:0][BITS-1:0]  h;
  logic [BITS-1:0]          y_q, lr_q, yhat_o, yhat_q, delta;
  logic [1:0]               mode_q;
  logic                     err_now, err_q;
  logic accept, fph_stb, fpo_stb, bpo_stb, bph_stb, upd, done;

  mlp_seq #(.PHC(PHC)) u_seq (
    .clk(clk), .rst(rst), .in_valid(in_valid), .wl_en(wl_en), .train(mode_q != MODE_VAL),
    .in_ready(in_ready), .accept(accept), .busy(busy),
    .fph_stb(fph_stb), .fpo_stb(fpo_stb), .bpo_stb(bpo_stb), .bph_stb(bph_stb),
    .upd(upd), .done(done)
  );

  for (genvar j = 0; j < NH; j++) begin : g_hid
    Neuron_ReLU #(.NX(NX), .BITS(BITS)) u_hid (
      .clk(clk), .rst(rst), .fp(fph_stb), .bp(bph_stb), .w(w1[j]), .x(x_q), .lr(lr_q),
      .delta(delta), .w_out(w2[j+1]), .h(h[j]), .w_new(w1_new[j])
    );
  end

  Neuron_Sigmoid #(.NH(NH), .BITS(BITS)) u_out (
    .clk(clk), .rst(rst), .fp(fpo_stb), .bp(bpo_stb), .w(w2), .h(h), .y(y_q), .lr(lr_q),
    .yhat(yhat_o), .delta(delta), .w_new(w2_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      lr_q   <= '0;
      mode_q <= MODE_VAL;
    end else if (accept) begin
      x_q    <= x;
      y_q    <= y;
      lr_q   <= lr;
      mode_q <= norm_mode(mode);
    end
  end

  // Loads are only legal while idle, so they can never collide with a commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      w1 <= '0;
      w2 <= '0;
    end else if (upd && mode_q == MODE_TRN) begin
      for (int u = 0; u < NH; u++) w1[u] <= w1_new[u];
      w2 <= w2_new;
    end else if (wl_en && !busy) begin
      if (wl_layer) begin
        for (int j = 0; j <= NH; j++) if (wl_addr == AW'(j)) w2[j] <= wl_data;
      end else begin
        for (int u = 0; u < NH; u++)
          for (int k = 0; k <= NX; k++)
            if (wl_addr == AW'(u*(NX+1) + k)) w1[u][k] <= wl_data;
      end
    end
  end

  always_comb begin
    wr_data = '0;
    if (wl_layer) begin
      for (int j = 0; j <= NH; j++) if (wl_addr == AW'(j)) wr_data = w2[j];
    end else begin
      for (int u = 0; u < NH; u++)
        for (int k = 0; k <= NX; k++)
          if (wl_addr == AW'(u*(NX+1) + k)) wr_data = w1[u][k];
    end
  end

  // Result is live during DONE and held from the register afterwards.
  assign err_now   = (yhat_o != y_q);
  assign out_valid = done;
  assign yhat      = done ? yhat_o : yhat_q;
  assign err       = done ? err_now : err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      yhat_q <= '0;
      err_q  <= 1'b0;
    end else if (done) begin
      yhat_q <= yhat_o;
      err_q  <= err_now;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      pat_cnt <= '0;
      err_cnt <= '0;
    end else if (done) begin
      if (pat_cnt != '1) pat_cnt <= pat_cnt + 1'b1;
      if (mode_q == MODE_VAL && err_now && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule
